// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared constants for the PS/2 set-2 scan-code decoder:
//   - prefix bytes (E0 extended, F0 break)
//   - bytes that carry no key information (ignore set) and is_ignored()
//   - 2-bit FSM state encoding used by ps2_scancode_decoder
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Bytes a keyboard sends that are not key codes (errors, BAT, ACK, resend, E1 pause prefix)
  localparam logic [7:0] PS2_IGN_ERR0   = 8'h00;
  localparam logic [7:0] PS2_IGN_BAT    = 8'hAA;
  localparam logic [7:0] PS2_IGN_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_IGN_ACK    = 8'hFA;
  localparam logic [7:0] PS2_IGN_BATERR = 8'hFC;
  localparam logic [7:0] PS2_IGN_RESEND = 8'hFE;
  localparam logic [7:0] PS2_IGN_ERR1   = 8'hFF;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Returns 1 for bytes that must be dropped without producing an event
  function automatic logic is_ignored(input logic [7:0] b);
    logic res;
    case (b)
      PS2_IGN_ERR0, PS2_IGN_BAT, PS2_IGN_PAUSE, PS2_IGN_ACK,
      PS2_IGN_BATERR, PS2_IGN_RESEND, PS2_IGN_ERR1: res = 1'b1;
      default:                                       res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_held_key_table.sv
// ---------------------------------------------------------------------------
// ps2_held_key_table
// Small table of currently held keys, each entry {valid, ext, code}.
// Lookup is combinational; insert/remove/clear take effect on the clock edge.
// Ports:
//   clk     in   clock
//   clear   in   synchronous clear of every entry (driven by block reset)
//   insert  in   store key in the lowest free slot (ignored if present/full)
//   remove  in   invalidate the entry matching key (ignored if absent)
//   key     in   9-bit key identity {ext, code}
//   hit     out  key is currently in the table
//   full    out  all MAX_HELD slots occupied
//   count   out  number of occupied slots (registered)
// ---------------------------------------------------------------------------
module ps2_held_key_table #(
  parameter int MAX_HELD = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       insert,
  input  logic       remove,
  input  logic [8:0] key,
  output logic       hit,
  output logic       full,
  output logic [3:0] count
);

  logic [MAX_HELD-1:0] valid_r;
  logic [8:0]          key_r [MAX_HELD];
  logic [3:0]          count_r;

  logic [MAX_HELD-1:0] match_s;
  logic [MAX_HELD-1:0] free_sel_s;
  logic                found_s;
  logic                insert_ok_s;
  logic                remove_ok_s;

  // Match every slot against the key and pick the lowest free slot
  always_comb begin
    match_s    = '0;
    free_sel_s = '0;
    found_s    = 1'b0;
    for (int i = 0; i < MAX_HELD; i++) begin
      match_s[i] = valid_r[i] && (key_r[i] == key);
      if (!valid_r[i] && !found_s) begin
        free_sel_s[i] = 1'b1;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign hit         = |match_s;
  assign full        = &valid_r;
  assign insert_ok_s = insert && !hit && !full;
  assign remove_ok_s = remove && hit;
  assign count       = count_r;

  // Slot storage: holes left by removal are reused, no compaction
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_r <= '0;
      for (int i = 0; i < MAX_HELD; i++) begin
        key_r[i] <= 9'd0;
      end
    end else begin
      for (int i = 0; i < MAX_HELD; i++) begin
        if (insert_ok_s && free_sel_s[i]) begin
          valid_r[i] <= 1'b1;
          key_r[i]   <= key;
        end else if (remove_ok_s && match_s[i]) begin
          valid_r[i] <= 1'b0;
        end else begin
          valid_r[i] <= valid_r[i];
        end
      end
    end
  end

  // Occupancy counter kept alongside the slots so it updates on the same edge
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= 4'd0;
    end else if (insert_ok_s) begin
      count_r <= count_r + 4'd1;
    end else if (remove_ok_s) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
// Turns raw PS/2 set-2 bytes into one make event per key press and one break
// event per key release. E0/F0 prefixes are folded into the event, typematic
// repeats are swallowed using a held-key table, and an abandoned prefix is
// dropped after TIMEOUT_CYCLES idle cycles.
// Ports:
//   CLOCK_50        in   system clock
//   reset           in   synchronous active-high reset
//   byte_in         in   received byte, qualified by byte_valid
//   byte_valid      in   1-cycle strobe per received byte
//   event_valid     out  1-cycle pulse, event_* carry a key event
//   event_code      out  scan code without prefixes (holds between events)
//   event_ext       out  code was E0-prefixed (holds between events)
//   event_is_break  out  1 release / 0 press (holds between events)
//   held_count      out  occupied held-key table entries
//   any_held        out  held_count != 0
//   overflow        out  1-cycle pulse, make dropped because table full
//   timeout_err     out  1-cycle pulse, pending prefix abandoned
// ---------------------------------------------------------------------------
module ps2_scancode_decoder #(
  parameter int MAX_HELD       = 4,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_is_break,
  output logic [3:0] held_count,
  output logic       any_held,
  output logic       overflow,
  output logic       timeout_err
);
  import ps2_pkg::*;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [TW-1:0] timer_r;

  logic          fin_valid_s;
  logic          fin_ext_s;
  logic          fin_brk_s;
  logic          timeout_s;
  logic [8:0]    key_s;
  logic          hit_s;
  logic          full_s;
  logic          insert_s;
  logic          remove_s;
  logic          event_s;
  logic          overflow_s;

  logic          event_valid_r;
  logic [7:0]    event_code_r;
  logic          event_ext_r;
  logic          event_is_break_r;
  logic          overflow_r;
  logic          timeout_err_r;

  // Prefix FSM: classify the incoming byte and detect prefix expiry
  always_comb begin
    state_nxt_s = state_r;
    fin_valid_s = 1'b0;
    fin_ext_s   = 1'b0;
    fin_brk_s   = 1'b0;
    timeout_s   = 1'b0;
    if (byte_valid) begin
      if (is_ignored(byte_in)) begin
        state_nxt_s = ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (byte_in == PS2_EXT) begin
              state_nxt_s = ST_EXT;
            end else if (byte_in == PS2_BRK) begin
              state_nxt_s = ST_BRK;
            end else begin
              state_nxt_s = ST_IDLE;
              fin_valid_s = 1'b1;
            end
          end
          ST_EXT: begin
            if (byte_in == PS2_BRK) begin
              state_nxt_s = ST_EXT_BRK;
            end else if (byte_in == PS2_EXT) begin
              state_nxt_s = ST_EXT;
            end else begin
              state_nxt_s = ST_IDLE;
              fin_valid_s = 1'b1;
              fin_ext_s   = 1'b1;
            end
          end
          ST_BRK: begin
            if (byte_in == PS2_BRK) begin
              state_nxt_s = ST_BRK;
            end else if (byte_in == PS2_EXT) begin
              state_nxt_s = ST_EXT_BRK;
            end else begin
              state_nxt_s = ST_IDLE;
              fin_valid_s = 1'b1;
              fin_brk_s   = 1'b1;
            end
          end
          ST_EXT_BRK: begin
            if ((byte_in == PS2_EXT) || (byte_in == PS2_BRK)) begin
              state_nxt_s = ST_EXT_BRK;
            end else begin
              state_nxt_s = ST_IDLE;
              fin_valid_s = 1'b1;
              fin_ext_s   = 1'b1;
              fin_brk_s   = 1'b1;
            end
          end
          default: begin
            state_nxt_s = ST_IDLE;
          end
        endcase
      end
    end else if ((state_r != ST_IDLE) && (timer_r == TIMER_LAST)) begin
      // A byte arriving in the expiry cycle takes the branch above instead
      state_nxt_s = ST_IDLE;
      timeout_s   = 1'b1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Table actions: a repeat make (hit) does nothing; a break is always reported
  always_comb begin
    key_s      = {fin_ext_s, byte_in};
    insert_s   = fin_valid_s && !fin_brk_s && !hit_s && !full_s;
    remove_s   = fin_valid_s && fin_brk_s && hit_s;
    event_s    = fin_valid_s && (fin_brk_s || (!hit_s && !full_s));
    overflow_s = fin_valid_s && !fin_brk_s && !hit_s && full_s;
  end

  ps2_held_key_table #(
    .MAX_HELD (MAX_HELD)
  ) u_table (
    .clk    (CLOCK_50),
    .clear  (reset),
    .insert (insert_s),
    .remove (remove_s),
    .key    (key_s),
    .hit    (hit_s),
    .full   (full_s),
    .count  (held_count)
  );

  // FSM state and prefix timer; timer runs only while a prefix is pending
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= ST_IDLE;
      timer_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (byte_valid || timeout_s || (state_r == ST_IDLE)) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TW'(1);
      end
    end
  end

  // Output registers: pulses last one cycle, event fields hold between events
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      event_valid_r    <= 1'b0;
      event_code_r     <= 8'd0;
      event_ext_r      <= 1'b0;
      event_is_break_r <= 1'b0;
      overflow_r       <= 1'b0;
      timeout_err_r    <= 1'b0;
    end else begin
      event_valid_r <= event_s;
      overflow_r    <= overflow_s;
      timeout_err_r <= timeout_s;
      if (event_s) begin
        event_code_r     <= byte_in;
        event_ext_r      <= fin_ext_s;
        event_is_break_r <= fin_brk_s;
      end else begin
        event_code_r     <= event_code_r;
        event_ext_r      <= event_ext_r;
        event_is_break_r <= event_is_break_r;
      end
    end
  end

  assign event_valid    = event_valid_r;
  assign event_code     = event_code_r;
  assign event_ext      = event_ext_r;
  assign event_is_break = event_is_break_r;
  assign overflow       = overflow_r;
  assign timeout_err    = timeout_err_r;
  assign any_held       = (held_count != 4'd0);

endmodule
